// File: rtl/sha1_stream_if.sv
// rtl/sha1_stream_if.sv - byte-message input stream bundle for sha1_stream
interface sha1_stream_if #(
  parameter int IN_BYTES = 4
);
  localparam int NB_W = $clog2(IN_BYTES) + 1;

  logic                  s_valid;
  logic                  s_ready;
  logic [8*IN_BYTES-1:0] s_data;
  logic                  s_last;
  logic [NB_W-1:0]       s_nbytes;

  modport master (output s_valid, s_data, s_last, s_nbytes, input s_ready);
  modport slave  (input s_valid, s_data, s_last, s_nbytes, output s_ready);
endinterface

// File: rtl/sha1_stream.sv
// rtl/sha1_stream.sv - SHA-1 message packer/padder that sequences an external sha1_update core
// Optional feature macro: SHA1_STREAM_RESUME_EN (resume_load/resume_h/resume_len ports).
module sha1_stream #(
  parameter int IN_BYTES = 4,
  parameter int LEN_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  sha1_stream_if.slave     s,
  output logic             core_start,
  output logic [511:0]     core_data,
  output logic [159:0]     core_hash_in,
  input  logic             core_done,
  input  logic [159:0]     core_hash_out,
`ifdef SHA1_STREAM_RESUME_EN
  input  logic             resume_load,
  input  logic [159:0]     resume_h,
  input  logic [LEN_W-4:0] resume_len,
`endif
  output logic             digest_valid,
  output logic [159:0]     digest,
  output logic             busy
);
  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [2:0] {FILL, RUN, PADBLK, RUN_PAD1, RUN_PAD2, FIN} state_t;

  state_t           state;
  logic [511:0]     blk_buf;
  logic [511:0]     merged;
  logic [511:0]     pad_blk;
  logic [511:0]     tail_blk;
  logic [6:0]       blk_cnt;
  logic [6:0]       cnt_next;
  logic [6:0]       n;
  logic [LEN_W-4:0] len;
  logic [LEN_W-4:0] len_base;
  logic [LEN_W-4:0] len_next;
  logic [159:0]     h;
  logic [159:0]     h_base;
  logic [63:0]      len_bits;
  logic             accept;

  assign s.s_ready = rst_n && (state == FILL);
  assign accept    = s.s_valid && s.s_ready;
  assign busy      = (state == FILL) ? (len != '0) : (state != FIN);
  assign n         = s.s_last ? 7'(s.s_nbytes) : 7'(IN_BYTES);
  assign cnt_next  = blk_cnt + n;
  assign len_next  = len_base + (LEN_W-3)'(n);
  assign len_bits  = 64'({len, 3'b000});

  // A resume load only takes effect at a message boundary and is seen by a same-cycle beat.
  always_comb begin
    h_base   = h;
    len_base = len;
`ifdef SHA1_STREAM_RESUME_EN
    if (state == FILL && blk_cnt == '0 && resume_load) begin
      h_base   = resume_h;
      len_base = resume_len;
    end
`endif
  end

  always_comb begin
    merged = blk_buf;
    for (int i = 0; i < IN_BYTES; i++) begin
      int idx;
      idx = int'(blk_cnt) + i;
      if (7'(i) < n && idx < 64)
        merged[511-8*idx -: 8] = s.s_data[8*IN_BYTES-1-8*i -: 8];
    end
  end

  // Bytes past the message are rebuilt here, so stale data from earlier blocks never leaks.
  always_comb begin
    pad_blk = '0;
    for (int j = 0; j < 64; j++) begin
      if (7'(j) < blk_cnt)
        pad_blk[511-8*j -: 8] = blk_buf[511-8*j -: 8];
      else if (7'(j) == blk_cnt)
        pad_blk[511-8*j -: 8] = 8'h80;
    end
    if (blk_cnt <= 7'd55)
      pad_blk[63:0] = len_bits;
    tail_blk = {(blk_cnt == 7'd64) ? 8'h80 : 8'h00, 440'd0, len_bits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= FILL;
      h            <= IV;
      len          <= '0;
      blk_cnt      <= '0;
      blk_buf      <= '0;
      core_start   <= 1'b0;
      core_data    <= '0;
      core_hash_in <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        FILL: begin
          h   <= h_base;
          len <= len_base;
          if (accept) begin
            blk_buf      <= merged;
            blk_cnt      <= cnt_next;
            len          <= len_next;
            digest_valid <= 1'b0;
            if (s.s_last) begin
              state <= PADBLK;
            end else if (cnt_next == 7'd64) begin
              core_start   <= 1'b1;
              core_data    <= merged;
              core_hash_in <= h_base;
              state        <= RUN;
            end
          end
        end
        RUN: begin
          if (core_done) begin
            h       <= core_hash_out;
            blk_cnt <= '0;
            state   <= FILL;
          end
        end
        PADBLK: begin
          core_start   <= 1'b1;
          core_data    <= pad_blk;
          core_hash_in <= h;
          state        <= (blk_cnt <= 7'd55) ? RUN_PAD2 : RUN_PAD1;
        end
        RUN_PAD1: begin
          if (core_done) begin
            h            <= core_hash_out;
            core_hash_in <= core_hash_out;
            core_data    <= tail_blk;
            core_start   <= 1'b1;
            state        <= RUN_PAD2;
          end
        end
        RUN_PAD2: begin
          if (core_done) begin
            h     <= core_hash_out;
            state <= FIN;
          end
        end
        FIN: begin
          digest       <= h;
          digest_valid <= 1'b1;
          h            <= IV;
          len          <= '0;
          blk_cnt      <= '0;
          state        <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sha1_stream.sv
// tb/tb_sha1_stream.sv - scoreboard bench for sha1_stream with a behavioural sha1_update core
`timescale 1ns/1ps
module tb_sha1_stream;
  localparam int IN_BYTES = 4;
  localparam int NB_W = $clog2(IN_BYTES) + 1;
  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef logic [7:0] bytes_t[$];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         core_start, core_done, digest_valid, busy;
  logic [511:0] core_data;
  logic [159:0] core_hash_in, core_hash_out, digest;

  int n_checks = 0;
  int n_pass = 0;
  logic [159:0] exp_q[$];
  int core_lat = 3;
  int start_cnt = 0;
  bit core_busy = 1'b0;
  bit gaps = 1'b1;

  sha1_stream_if #(.IN_BYTES(IN_BYTES)) sif();

`ifdef SHA1_STREAM_RESUME_EN
  logic         resume_load = 1'b0;
  logic [159:0] resume_h = '0;
  logic [60:0]  resume_len = '0;
`endif

  sha1_stream #(.IN_BYTES(IN_BYTES), .LEN_W(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s(sif.slave),
    .core_start(core_start),
    .core_data(core_data),
    .core_hash_in(core_hash_in),
    .core_done(core_done),
    .core_hash_out(core_hash_out),
`ifdef SHA1_STREAM_RESUME_EN
    .resume_load(resume_load),
    .resume_h(resume_h),
    .resume_len(resume_len),
`endif
    .digest_valid(digest_valid),
    .digest(digest),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [159:0] sha1_compress(input logic [159:0] hin, input logic [511:0] blk);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = hin;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);         k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                  k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                  k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  // Textbook SHA-1: pad the whole byte queue, then chain the blocks from IV.
  function automatic logic [159:0] sha1_ref(input bytes_t m);
    bytes_t p;
    logic [63:0] bitlen;
    logic [511:0] blk;
    logic [159:0] hv;
    p = m;
    bitlen = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    hv = IV;
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b + j];
      hv = sha1_compress(hv, blk);
    end
    return hv;
  endfunction

  // Behavioural sha1_update: fixed latency, checks its inputs stay put while it works.
  initial begin
    logic [511:0] d;
    logic [159:0] hi;
    bit stable, aborted;
    core_done = 1'b0;
    core_hash_out = '0;
    @(posedge clk); #1;
    forever begin
      if (rst_n && core_start) begin
        d = core_data; hi = core_hash_in;
        stable = 1'b1; aborted = 1'b0;
        core_busy = 1'b1;
        start_cnt++;
        repeat (core_lat) begin
          @(posedge clk); #1;
          if (!rst_n) aborted = 1'b1;
          else if (!aborted && (core_data !== d || core_hash_in !== hi)) stable = 1'b0;
        end
        if (!aborted) check(stable, "core_inputs_stable", {159'd0, stable}, 160'd1);
        core_done = 1'b1;
        core_hash_out = sha1_compress(hi, d);
        @(posedge clk); #1;
        core_done = 1'b0;
        core_busy = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  initial begin
    bit prev;
    logic [159:0] e;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && digest_valid && !prev) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_digest", digest, '0);
        end else begin
          e = exp_q.pop_front();
          check(digest === e, "digest", digest, e);
        end
      end
      prev = digest_valid;
    end
  end

  task automatic drive_beat(input logic [8*IN_BYTES-1:0] d, input bit l, input int k, input bit first);
    int t;
    t = 0;
    sif.s_valid = 1'b1;
    sif.s_data = d;
    sif.s_last = l;
    sif.s_nbytes = l ? NB_W'(k) : NB_W'($urandom);
    @(negedge clk);
    while (!sif.s_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_checks++;
      $display("FAIL beat_accept_timeout: waited %0d cycles, limit 3000", t);
    end
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
    if (first) check(digest_valid == 1'b0, "digest_valid_clear", {159'd0, digest_valid}, '0);
  endtask

  task automatic send_msg(input bytes_t m, input bit last, input logic [159:0] exp);
    int nb, pos, k;
    bit first, is_last;
    logic [8*IN_BYTES-1:0] d;
    nb = m.size(); pos = 0; first = 1'b1;
    if (last) exp_q.push_back(exp);
    do begin
      k = (nb - pos >= IN_BYTES) ? IN_BYTES : nb - pos;
      is_last = last && (pos + k == nb);
      d = $urandom;
      for (int i = 0; i < k; i++) d[8*IN_BYTES-1-8*i -: 8] = m[pos+i];
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive_beat(d, is_last, k, first);
      first = 1'b0;
      pos += k;
    end while (pos < nb);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || core_busy) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check(t < 3000, {name, "_timeout"}, t, 160'd3000);
    @(posedge clk); #1;
  endtask

  initial begin
    bytes_t m;
    string s;
    int t, len, blocks;
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    sif.s_last = 1'b0;
    sif.s_nbytes = '0;

    repeat (3) @(posedge clk);
    #1;
    check(sif.s_ready == 1'b0, "ready_in_reset", {159'd0, sif.s_ready}, '0);
    check(digest_valid == 1'b0, "digest_valid_reset", {159'd0, digest_valid}, '0);
    check(digest == '0, "digest_reset", digest, '0);
    check(busy == 1'b0, "busy_reset", {159'd0, busy}, '0);
    check(core_start == 1'b0, "core_start_reset", {159'd0, core_start}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check(sif.s_ready == 1'b1, "ready_after_reset", {159'd0, sif.s_ready}, 160'd1);
    @(posedge clk); #1;

    // empty message
    start_cnt = 0; m.delete();
    send_msg(m, 1'b1, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);
    wait_idle("empty");
    check(start_cnt == 1, "empty_starts", start_cnt, 160'd1);

    // "abc"
    start_cnt = 0; m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b1, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
    wait_idle("abc");
    check(start_cnt == 1, "abc_starts", start_cnt, 160'd1);

    // 56-byte message: padding spills into a second block
    start_cnt = 0; m.delete();
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    send_msg(m, 1'b1, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1);
    wait_idle("msg56");
    check(start_cnt == 2, "msg56_starts", start_cnt, 160'd2);

    // 64 and 65 bytes with a slow core
    core_lat = 10;
    for (int r = 64; r <= 65; r++) begin
      start_cnt = 0; m.delete();
      for (int i = 0; i < r; i++) m.push_back(8'($urandom));
      send_msg(m, 1'b1, sha1_ref(m));
      wait_idle("msg64_65");
      check(start_cnt == 2, "msg64_65_starts", start_cnt, 160'd2);
    end

    // reset while the core is working on a full block
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    send_msg(m, 1'b0, '0);
    t = 0;
    while (!core_busy && t < 200) begin @(posedge clk); #1; t++; end
    check(t < 200, "run_entry_timeout", t, 160'd200);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check(busy == 1'b0, "busy_after_midreset", {159'd0, busy}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check(sif.s_ready == 1'b1, "ready_after_midreset", {159'd0, sif.s_ready}, 160'd1);
    t = 0;
    while (core_busy && t < 200) begin @(posedge clk); #1; t++; end
    repeat (2) begin @(posedge clk); #1; end
    check(sif.s_ready == 1'b1, "ready_after_stale_done", {159'd0, sif.s_ready}, 160'd1);
    start_cnt = 0; m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b1, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
    wait_idle("abc_after_reset");
    check(start_cnt == 1, "abc_after_reset_starts", start_cnt, 160'd1);

    // back-to-back messages, no idle cycles on the input
    core_lat = 4; gaps = 1'b0; start_cnt = 0;
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b1, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
    m.delete();
    send_msg(m, 1'b1, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);
    wait_idle("back_to_back");
    check(start_cnt == 2, "back_to_back_starts", start_cnt, 160'd2);

    // random lengths and core latencies
    gaps = 1'b1;
    for (int r = 0; r < 10; r++) begin
      len = (r < 3) ? 56 + $urandom_range(0, 7) : $urandom_range(0, 140);
      core_lat = $urandom_range(1, 6);
      blocks = (len + 9 + 63) / 64;
      start_cnt = 0; m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      send_msg(m, 1'b1, sha1_ref(m));
      wait_idle("random");
      check(start_cnt == blocks, "random_starts", start_cnt, blocks);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
